piso_tx: RTL
============

Name: piso_tx

Overview:
- Parallel-to-serial transmitter. Accepts an N-bit word through a valid/ready load handshake and shifts it out one bit per clock, MSB first.
- Serves as the transmit end of the team's serial-to-parallel receiver link, and produces the same 8-bit MSB-first bit order by default.
- Adds `busy`/`done` status so upstream logic can stream words back-to-back with no idle gap.

Parameters:
- WIDTH, 8, word length in bits; legal range WIDTH >= 2.
- MSB_FIRST, 1, 1 = transmit bit WIDTH-1 first; 0 = transmit bit 0 first.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  synchronous, active-low reset.
- load_valid  input  1  upstream asserts when p_in holds a word to send.
- load_ready  output  1  block can accept a word this cycle.
- p_in  input  WIDTH  parallel word; sampled only on an accepted handshake.
- s  output  1  serial data bit.
- s_valid  output  1  high in every cycle where s carries a frame bit.
- busy  output  1  high while a frame is in flight (state != IDLE).
- done  output  1  one-cycle pulse during the final bit cycle of a frame.

Behaviour:
- Reset (clk edge with reset=0):
  - state=IDLE; shift register=0; bit counter=0.
  - Outputs: s=0, s_valid=0, busy=0, done=0, load_ready=1 (load_ready is combinational from state).
  - Reset has priority over every other event, including mid-frame. An in-flight word is discarded with no done pulse.
- States: IDLE, SHIFT (plus PARITY when the optional feature is compiled in).
- Handshake acceptance:
  - Accept = load_valid && load_ready at a posedge.
  - On accept: capture p_in into the shift register; counter <= WIDTH-1; state <= SHIFT.
  - Counter width is $clog2(WIDTH).
- Timing, for an accept at edge k:
  - Bit i of the frame (i = 0..WIDTH-1) is presented on s during the cycle after edge k+i. Latency from accept to first bit is 1 cycle.
  - s is taken from the shift register's output end: bit WIDTH-1 when MSB_FIRST=1, bit 0 otherwise.
  - Each edge in SHIFT shifts the register toward that end and decrements the counter.
- Outputs by state:
  - IDLE: s=0, s_valid=0, busy=0, load_ready=1.
  - SHIFT: s_valid=1, busy=1.
- load_ready rules:
  - 0 during SHIFT while counter != 0.
  - 1 during the last bit cycle (counter == 0).
  - If a load is accepted at the end of the last bit: the new word loads, state stays SHIFT, and its first bit follows in the next cycle with zero gap. done still pulses for the finishing frame.
  - If no load at the end of the last bit: state <= IDLE.
- done = (state==SHIFT && counter==0). It is combinational, one cycle per frame.
- load_valid and p_in are ignored whenever load_ready=0. p_in changes mid-frame do not affect the transmitted word.
- Holding load_valid high continuously produces back-to-back frames, each WIDTH cycles long.

Optional Feature:
- Macro: PISO_PARITY_EN.
- Defined:
  - After the last data bit the FSM enters PARITY for one cycle.
  - In PARITY: s = even parity (XOR of all WIDTH captured bits); s_valid=1; busy=1.
  - done and load_ready move from the last data cycle to the PARITY cycle, and back-to-back acceptance happens at the end of PARITY.
  - Frame length becomes WIDTH+1 cycles. Parity is computed at capture and stored in a 1-bit register.
- Undefined:
  - No PARITY state and no parity register; frame length is WIDTH cycles.

Test Plan:
- Reset then single frame: reset=0 for 2 cycles, then load 8'hA5 with one-cycle load_valid.
  - Expect s = 1,0,1,0,0,1,0,1 over 8 cycles with s_valid=1.
  - Expect done high only on the 8th bit, then s_valid=0 and busy=0.
- Back-to-back: load_valid held high with p_in=8'hA5, then 8'h3C on the last bit cycle.
  - Expect 16 consecutive s_valid cycles: 10100101 00111100.
  - Expect two done pulses, 8 cycles apart.
- Ignore during busy: accept 8'hFF, then on cycle 3 assert load_valid with p_in=8'h00.
  - Expect load_ready=0 and the frame to stay 11111111.
  - Expect 8'h00 to be accepted only at the last bit cycle.
- Reset mid-frame: accept 8'hC3 and pull reset low after 3 bits.
  - Expect the next cycle to show s=0, s_valid=0, busy=0, load_ready=1, with no done pulse.
  - Expect a following load of 8'h81 to transmit cleanly.
- LSB-first and loopback:
  - With MSB_FIRST=0, 8'h01 transmits 1,0,0,0,0,0,0,0.
  - With MSB_FIRST=1, drive s into the serial-to-parallel receiver, releasing the receiver's reset so its first capture edge samples bit 0. Its 8-bit parallel output must equal 8'h5A after 8 cycles.
- Parity (PISO_PARITY_EN defined):
  - 8'hA5 yields 9 bits, ending in parity 0.
  - 8'h07 yields 9 bits, ending in parity 1.
  - done pulses on the 9th cycle in both cases.

Source files
------------

// File: rtl/piso_tx.sv
// piso_tx: parallel-to-serial transmitter with valid/ready load handshake.
// Optional trailing even-parity bit when PISO_PARITY_EN is defined.
module piso_tx #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] p_in,
    output logic             s,
    output logic             s_valid,
    output logic             busy,
    output logic             done
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

`ifdef PISO_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
    typedef enum logic {IDLE, SHIFT} state_t;
`endif

    state_t           state_q;
    logic [WIDTH-1:0] shreg_q;
    logic [WIDTH-1:0] shift_d;
    logic [CW-1:0]    cnt_q;
    logic             out_bit;
    logic             last_bit;
    logic             accept;
`ifdef PISO_PARITY_EN
    logic             parity_q;
`endif

    assign last_bit = (cnt_q == '0);
    assign accept   = load_valid && load_ready;

    // Shift toward the serial output end; vacated bits fill with zero.
    always_comb begin
        if (MSB_FIRST) begin
            shift_d = {shreg_q[WIDTH-2:0], 1'b0};
            out_bit = shreg_q[WIDTH-1];
        end else begin
            shift_d = {1'b0, shreg_q[WIDTH-1:1]};
            out_bit = shreg_q[0];
        end
    end

    // Status and serial outputs decoded from the current state.
    always_comb begin
        load_ready = 1'b1;
        s          = 1'b0;
        s_valid    = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state_q)
            SHIFT: begin
                s       = out_bit;
                s_valid = 1'b1;
                busy    = 1'b1;
`ifdef PISO_PARITY_EN
                load_ready = 1'b0;
`else
                load_ready = last_bit;
                done       = last_bit;
`endif
            end
`ifdef PISO_PARITY_EN
            PARITY: begin
                s          = parity_q;
                s_valid    = 1'b1;
                busy       = 1'b1;
                done       = 1'b1;
                load_ready = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    // Frame FSM: a new word may load on the final cycle of a frame.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            shreg_q  <= '0;
            cnt_q    <= '0;
`ifdef PISO_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else if (accept) begin
            state_q  <= SHIFT;
            shreg_q  <= p_in;
            cnt_q    <= CW'(WIDTH - 1);
`ifdef PISO_PARITY_EN
            parity_q <= ^p_in;
`endif
        end else begin
            case (state_q)
                SHIFT: begin
                    shreg_q <= shift_d;
                    if (last_bit) begin
`ifdef PISO_PARITY_EN
                        state_q <= PARITY;
`else
                        state_q <= IDLE;
`endif
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
`ifdef PISO_PARITY_EN
                PARITY: state_q <= IDLE;
`endif
                default: ;
            endcase
        end
    end

endmodule
